// File: rtl/heap_sort_pkg.sv
// Shared types and helpers for the heap sort engine.
//   state_t : FSM state encoding for the top-level controller
//   sel_t   : result of the node/left/right max-select
//   lchild / rchild : 1-based heap child index arithmetic
package heap_sort_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    BUILD   = 3'd2,
    HEAPIFY = 3'd3,
    EMIT    = 3'd4,
    EXTRACT = 3'd5,
    DONE    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SEL_NODE  = 2'd0,
    SEL_LEFT  = 2'd1,
    SEL_RIGHT = 2'd2
  } sel_t;

  // Heap is 1-based: children of i are 2i and 2i+1.
  function automatic int unsigned lchild(input int unsigned i);
    return i * 2;
  endfunction

  function automatic int unsigned rchild(input int unsigned i);
    return i * 2 + 1;
  endfunction

endpackage

// File: rtl/heap_sort_sel.sv
// Combinational max-select among a heap node and its (optional) children.
// Ports:
//   node_v, left_v, right_v : candidate values (unsigned)
//   has_left, has_right     : child exists within the current heap size
//   sel                     : which candidate is largest
// Ties: node beats either child, left beats right.
module heap_sort_sel
  import heap_sort_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] node_v,
  input  logic [DATA_W-1:0] left_v,
  input  logic [DATA_W-1:0] right_v,
  input  logic              has_left,
  input  logic              has_right,
  output sel_t              sel
);

  logic [DATA_W-1:0] best;

  // Strict '>' comparisons give the earlier candidate priority on ties.
  always_comb begin
    best = node_v;
    sel  = SEL_NODE;
    if (has_left && (left_v > best)) begin
      best = left_v;
      sel  = SEL_LEFT;
    end
    if (has_right && (right_v > best)) begin
      best = right_v;
      sel  = SEL_RIGHT;
    end
  end

endmodule

// File: rtl/heap_sort_engine.sv
// Batch heap sorter: loads len words from a 1-cycle-latency ROM into a
// register array, max-heap sorts them and writes the result to a RAM.
// Ports:
//   clk, reset (sync, active-low)
//   start, len, descend : job request, sampled when idle or done
//   busy, done          : job status
//   rom_rd, rom_a, rom_q: ROM read port (data one cycle after address)
//   ram_valid, ram_a, ram_d : RAM write port, one strobe per emitted word
// Handshake: start is accepted on any rising edge where busy=0; busy rises on
// the next cycle and stays high until the job enters DONE, where done is held
// high until the next accepted start or reset.
module heap_sort_engine
  import heap_sort_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              descend,
  output logic              busy,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [DATA_W-1:0] rom_q,
  output logic              ram_valid,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              done
);

  localparam int NUM_W = ADDR_W + 1;
  localparam int IDX_W = ADDR_W + 2;  // wide enough that 2i+1 never wraps

  state_t            state, next_state;
  logic [NUM_W-1:0]  len_q, cnt, num, len_clamped;
  logic              descend_q, caller_emit, accept, swap;
  logic [IDX_W-1:0]  root, node, lc, rc, largest, num_x;
  logic [DATA_W-1:0] node_v, left_v, right_v, largest_v;
  logic              has_left, has_right;
  sel_t              sel;
  logic [ADDR_W-1:0] emit_a, ram_a_q;
  logic [DATA_W-1:0] ram_d_q;

  // Logical heap A[1:DEPTH] is stored as mem[0:DEPTH-1], A[i] = mem[i-1].
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [ADDR_W-1:0] ix(input logic [IDX_W-1:0] i);
    return ADDR_W'(i - IDX_W'(1));
  endfunction

  assign len_clamped = (len > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : len;
  assign accept      = start && ((state == IDLE) || (state == DONE));

  // Heapify step: compare node with its children inside the live heap.
  always_comb begin
    lc        = IDX_W'(lchild(32'(node)));
    rc        = IDX_W'(rchild(32'(node)));
    num_x     = IDX_W'(num);
    has_left  = (lc <= num_x);
    has_right = (rc <= num_x);
    node_v    = mem[ix(node)];
    left_v    = has_left  ? mem[ix(lc)] : '0;
    right_v   = has_right ? mem[ix(rc)] : '0;
  end

  heap_sort_sel #(.DATA_W(DATA_W)) u_sel (
    .node_v    (node_v),
    .left_v    (left_v),
    .right_v   (right_v),
    .has_left  (has_left),
    .has_right (has_right),
    .sel       (sel)
  );

  always_comb begin
    largest   = node;
    largest_v = node_v;
    if (sel == SEL_LEFT) begin
      largest   = lc;
      largest_v = left_v;
    end else if (sel == SEL_RIGHT) begin
      largest   = rc;
      largest_v = right_v;
    end
  end

  assign swap   = (sel != SEL_NODE);
  // cnt is the emit index k during EMIT; largest element goes to the top
  // address first when ascending.
  assign emit_a = descend_q ? cnt[ADDR_W-1:0] : ADDR_W'(len_q - NUM_W'(1) - cnt);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (accept) next_state = (len_clamped == '0) ? DONE : LOAD;
      LOAD:       if (cnt == len_q) next_state = BUILD;
      BUILD:      next_state = (root == '0) ? EMIT : HEAPIFY;
      HEAPIFY:    if (!swap) next_state = caller_emit ? EMIT : BUILD;
      EMIT:       next_state = (num == NUM_W'(1)) ? DONE : EXTRACT;
      EXTRACT:    next_state = HEAPIFY;
      default:    next_state = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    rom_rd    = (state == LOAD) && (cnt < len_q);
    rom_a     = rom_rd ? cnt[ADDR_W-1:0] : '0;
    ram_valid = (state == EMIT);
    ram_a     = ram_valid ? emit_a : ram_a_q;
    ram_d     = ram_valid ? mem[0] : ram_d_q;
  end

  // Datapath: counters, heap array and held RAM outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_q       <= '0;
      cnt         <= '0;
      num         <= '0;
      descend_q   <= 1'b0;
      caller_emit <= 1'b0;
      root        <= '0;
      node        <= '0;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            len_q     <= len_clamped;
            descend_q <= descend;
            cnt       <= '0;
          end
        end
        LOAD: begin
          // Data for address cnt-1 arrives now; it belongs at A[cnt].
          if (cnt != '0) mem[ix(IDX_W'(cnt))] <= rom_q;
          if (cnt == len_q) begin
            root <= IDX_W'(len_q >> 1);
            num  <= len_q;
            cnt  <= '0;
          end else begin
            cnt <= cnt + NUM_W'(1);
          end
        end
        BUILD: begin
          if (root != '0) begin
            node        <= root;
            root        <= root - IDX_W'(1);
            caller_emit <= 1'b0;
          end
        end
        HEAPIFY: begin
          if (swap) begin
            mem[ix(node)]    <= largest_v;
            mem[ix(largest)] <= node_v;
            node             <= largest;
          end
        end
        EMIT: begin
          ram_a_q <= emit_a;
          ram_d_q <= mem[0];
          cnt     <= cnt + NUM_W'(1);
        end
        EXTRACT: begin
          mem[0]      <= mem[ix(IDX_W'(num))];
          num         <= num - NUM_W'(1);
          node        <= IDX_W'(1);
          caller_emit <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
